// File: rtl/itof_pkg.sv
// itof_pkg: shared state encoding, default counter width and saturation helper
// for the iTOF frame controller.
package itof_pkg;

    localparam int CNT_W = 12;

    typedef enum logic [1:0] {IDLE, INTEG, LATCH, READOUT} state_t;

    function automatic logic [31:0] cnt_max(input int width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/itof_frame_controller_if.sv
// itof_frame_controller_if: frame result bus towards output_buffer with a
// valid/ready handshake.
interface itof_frame_controller_if #(parameter int CNT_W = itof_pkg::CNT_W);

    logic [CNT_W-1:0] memory1;
    logic [CNT_W-1:0] memory2;
    logic             buf_en;
    logic             out_valid;
    logic             out_ready;
    logic             overflow;

    modport master(output memory1, memory2, buf_en, out_valid, overflow, input out_ready);
    modport slave(input memory1, memory2, buf_en, out_valid, overflow, output out_ready);

endinterface

// File: rtl/itof_tap_counter.sv
// itof_tap_counter: saturating up-counter for one demodulation tap; clr wins
// over inc, sat_hit flags an increment attempted at full scale.
module itof_tap_counter
    import itof_pkg::*;
#(
    parameter int CNT_W = itof_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat_hit
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

    assign sat_hit = inc & (count == MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && !sat_hit)
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/itof_frame_controller.sv
// itof_frame_controller: sequences one two-tap iTOF frame (integrate, latch,
// present with valid/ready) for a single SPAD pixel.
module itof_frame_controller
    import itof_pkg::*;
#(
    parameter int CNT_W       = itof_pkg::CNT_W,
    parameter int INT_CYCLES  = 1000,
    parameter int HALF_PERIOD = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   continuous,
    input  logic                   spad_pulse,
    output logic                   tap_sel,
    output logic                   busy,
    itof_frame_controller_if.master bus
);

    localparam int CW = $clog2(INT_CYCLES + 1);
    localparam int HW = $clog2(HALF_PERIOD + 1);

    state_t           state, nxt;
    logic [CW-1:0]    cyc;
    logic [HW-1:0]    ph;
    logic             flag;
    logic [CNT_W-1:0] cnt0, cnt1;
    logic             hit0, hit1;
    logic             last, half_end, hs, integ, clr;

    assign integ    = state == INTEG;
    assign clr      = state == LATCH;
    assign last     = cyc == CW'(INT_CYCLES - 1);
    assign half_end = ph == HW'(HALF_PERIOD - 1);
    assign hs       = bus.out_valid & bus.out_ready;

    always_comb
        nxt = state == IDLE  ? (start ? INTEG : IDLE) :
              state == INTEG ? (last ? LATCH : INTEG) :
              state == LATCH ? READOUT :
              hs             ? (continuous ? INTEG : IDLE) : READOUT;

    itof_tap_counter #(.CNT_W(CNT_W)) u_tap0 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .inc(integ & spad_pulse & ~tap_sel), .count(cnt0), .sat_hit(hit0)
    );

    itof_tap_counter #(.CNT_W(CNT_W)) u_tap1 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .inc(integ & spad_pulse & tap_sel), .count(cnt1), .sat_hit(hit1)
    );

    // Cycle/phase counters idle at zero so every INTEG entry starts on tap0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cyc           <= '0;
            ph            <= '0;
            tap_sel       <= 1'b0;
            flag          <= 1'b0;
            busy          <= 1'b0;
            bus.memory1   <= '0;
            bus.memory2   <= '0;
            bus.overflow  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.buf_en    <= 1'b0;
        end else begin
            state         <= nxt;
            busy          <= nxt != IDLE;
            bus.out_valid <= nxt == READOUT;
            bus.buf_en    <= nxt == READOUT;
            flag          <= clr ? 1'b0 : flag | hit0 | hit1;
            if (integ && !last) begin
                cyc     <= cyc + CW'(1);
                ph      <= half_end ? '0 : ph + HW'(1);
                tap_sel <= tap_sel ^ half_end;
            end else begin
                cyc     <= '0;
                ph      <= '0;
                tap_sel <= 1'b0;
            end
            if (clr) begin
                bus.memory1  <= cnt0;
                bus.memory2  <= cnt1;
                bus.overflow <= flag;
            end
        end
    end

endmodule

// File: tb/tb_itof_frame_controller.sv
// tb_itof_frame_controller: directed checks of framing, tap alternation,
// saturation, backpressure, continuous mode and asynchronous abort.
module tb_itof_frame_controller;

    logic clk = 1'b0;
    logic rst_na, rst_nb;
    logic start_a, cont_a, sp_a, gate_a, rdy_a, tap_a, busy_a, spad_a;
    logic start_b, sp_b, rdy_b, tap_b, busy_b, spad_b;
    logic [15:0] pat;
    int n_cmp = 0;
    int n_bad = 0;
    int n;

    always #5 clk = ~clk;

    itof_frame_controller_if #(.CNT_W(12)) ia();
    itof_frame_controller_if #(.CNT_W(12)) ib();

    assign spad_a       = gate_a ? sp_a & ~tap_a : sp_a;
    assign spad_b       = sp_b & ~tap_b;
    assign ia.out_ready = rdy_a;
    assign ib.out_ready = rdy_b;

    itof_frame_controller #(.CNT_W(12), .INT_CYCLES(16), .HALF_PERIOD(4)) dut_a (
        .clk(clk), .rst_n(rst_na), .start(start_a), .continuous(cont_a),
        .spad_pulse(spad_a), .tap_sel(tap_a), .busy(busy_a), .bus(ia)
    );

    itof_frame_controller #(.CNT_W(12), .INT_CYCLES(10000), .HALF_PERIOD(1)) dut_b (
        .clk(clk), .rst_n(rst_nb), .start(start_b), .continuous(1'b0),
        .spad_pulse(spad_b), .tap_sel(tap_b), .busy(busy_b), .bus(ib)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_zero_a(input string p);
        check({p, "_tap"}, tap_a, 0);
        check({p, "_busy"}, busy_a, 0);
        check({p, "_buf_en"}, ia.buf_en, 0);
        check({p, "_valid"}, ia.out_valid, 0);
        check({p, "_ovf"}, ia.overflow, 0);
        check({p, "_mem1"}, ia.memory1, 0);
        check({p, "_mem2"}, ia.memory2, 0);
    endtask

    task automatic wait_valid_a(input int lim, output int cnt);
        cnt = 0;
        do begin
            tick();
            start_a = 1'b0;
            cnt++;
        end while (!ia.out_valid && cnt < lim);
        check("valid_a", ia.out_valid, 1);
    endtask

    task automatic wait_valid_b(input int lim, output int cnt);
        cnt = 0;
        do begin
            tick();
            start_b = 1'b0;
            cnt++;
        end while (!ib.out_valid && cnt < lim);
        check("valid_b", ib.out_valid, 1);
    endtask

    task automatic hs_a(input logic c);
        rdy_a  = 1'b1;
        cont_a = c;
        tick();
        rdy_a  = 1'b0;
    endtask

    initial begin
        {start_a, cont_a, sp_a, gate_a, rdy_a, start_b, sp_b, rdy_b} = '0;
        rst_na = 1'b0;
        rst_nb = 1'b0;
        repeat (2) tick();
        chk_zero_a("rst");
        check("rst_b_busy", busy_b, 0);
        check("rst_b_valid", ib.out_valid, 0);
        rst_na = 1'b1;
        rst_nb = 1'b1;
        tick();

        // Every INTEG cycle pulses: 8 counts per tap, 18-cycle latency.
        sp_a    = 1'b1;
        start_a = 1'b1;
        wait_valid_a(100, n);
        check("t1_latency", n, 18);
        check("t1_mem1", ia.memory1, 8);
        check("t1_mem2", ia.memory2, 8);
        check("t1_ovf", ia.overflow, 0);
        check("t1_buf_en", ia.buf_en, 1);
        check("t1_busy", busy_a, 1);
        sp_a = 1'b0;
        hs_a(1'b0);
        check("t1_valid_drop", ia.out_valid, 0);
        check("t1_buf_drop", ia.buf_en, 0);
        check("t1_idle", busy_a, 0);
        check("t1_mem1_hold", ia.memory1, 8);

        // Pulses only on tap0; record the tap_sel sequence.
        gate_a  = 1'b1;
        sp_a    = 1'b1;
        start_a = 1'b1;
        pat     = '0;
        for (int i = 0; i < 16; i++) begin
            tick();
            start_a = 1'b0;
            pat = {pat[14:0], tap_a};
        end
        check("t2_pattern", pat, 16'h0F0F);
        wait_valid_a(10, n);
        check("t2_tail", n, 2);
        check("t2_mem1", ia.memory1, 8);
        check("t2_mem2", ia.memory2, 0);

        // Backpressure with spad activity: result must stay frozen.
        gate_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sp_a = i[0];
            tick();
            check("t4_valid", ia.out_valid, 1);
            check("t4_mem1", ia.memory1, 8);
            check("t4_mem2", ia.memory2, 0);
        end
        sp_a = 1'b0;
        hs_a(1'b0);
        check("t4_valid_drop", ia.out_valid, 0);
        check("t4_buf_drop", ia.buf_en, 0);
        check("t4_idle", busy_a, 0);

        // Continuous: 3 tap0 pulses, then 5 (cycles 0-3 and 8) with no carry-over.
        gate_a  = 1'b1;
        sp_a    = 1'b0;
        start_a = 1'b1;
        n = 0;
        do begin
            tick();
            start_a = 1'b0;
            n++;
            sp_a = n <= 3;
        end while (!ia.out_valid && n < 100);
        check("t5a_latency", n, 18);
        check("t5a_mem1", ia.memory1, 3);
        check("t5a_mem2", ia.memory2, 0);
        rdy_a  = 1'b1;
        cont_a = 1'b1;
        n = 0;
        do begin
            tick();
            rdy_a = 1'b0;
            n++;
            if (n == 1) begin
                check("t5_reenter_busy", busy_a, 1);
                check("t5_reenter_valid", ia.out_valid, 0);
            end
            sp_a = n <= 9;
        end while (!ia.out_valid && n < 100);
        check("t5b_latency", n, 18);
        check("t5b_mem1", ia.memory1, 5);
        check("t5b_mem2", ia.memory2, 0);
        check("t5b_ovf", ia.overflow, 0);
        sp_a = 1'b0;
        hs_a(1'b0);
        check("t5_idle", busy_a, 0);

        // Abort mid-INTEG at cycle 7, then a clean frame.
        gate_a  = 1'b0;
        sp_a    = 1'b1;
        start_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            start_a = 1'b0;
        end
        check("t6_integ_busy", busy_a, 1);
        #2 rst_na = 1'b0;
        #1 chk_zero_a("t6_abort");
        tick();
        rst_na = 1'b1;
        tick();
        check("t6_post_idle", busy_a, 0);
        start_a = 1'b1;
        wait_valid_a(100, n);
        check("t6_latency", n, 18);
        check("t6_mem1", ia.memory1, 8);
        check("t6_mem2", ia.memory2, 8);
        #2 rst_na = 1'b0;
        #1 chk_zero_a("t6_abort_ro");
        tick();
        rst_na = 1'b1;
        gate_a  = 1'b1;
        start_a = 1'b1;
        wait_valid_a(100, n);
        check("t6_clean_mem1", ia.memory1, 8);
        check("t6_clean_mem2", ia.memory2, 0);
        check("t6_clean_ovf", ia.overflow, 0);
        sp_a = 1'b0;
        hs_a(1'b0);

        // Long window, HALF_PERIOD=1: 5000 tap0 pulses saturate at 4095.
        sp_b    = 1'b1;
        start_b = 1'b1;
        wait_valid_b(10100, n);
        check("t3_latency", n, 10002);
        check("t3_mem1", ib.memory1, 4095);
        check("t3_mem2", ib.memory2, 0);
        check("t3_ovf", ib.overflow, 1);
        sp_b  = 1'b0;
        rdy_b = 1'b1;
        tick();
        rdy_b = 1'b0;
        check("t3_idle", busy_b, 0);
        start_b = 1'b1;
        wait_valid_b(10100, n);
        check("t3b_mem1", ib.memory1, 0);
        check("t3b_mem2", ib.memory2, 0);
        check("t3b_ovf", ib.overflow, 0);
        rdy_b = 1'b1;
        tick();
        rdy_b = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
